// File: rtl/cpu_pkg.sv
// Shared types and constants for the exp12 front-end control path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

  // IF/ID sequencing states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } ifid_state_e;

  // PC loaded into IF/ID on a flush: one word below the reset PC, so a bubble
  // never aliases a real instruction address.
  localparam logic [31:0] IFID_FLUSH_PC    = 32'h1bfffffc;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  // Flush target selection: exception beats ertn beats branch.
  function automatic logic [31:0] flush_target(
    input logic        ex,
    input logic        ertn,
    input logic [31:0] ex_pc,
    input logic [31:0] era_pc,
    input logic [31:0] br_pc
  );
    if (ex)        return ex_pc;
    else if (ertn) return era_pc;
    else           return br_pc;
  endfunction

endpackage

// File: rtl/fetch_track.sv
// Tracks in-flight fetch requests and how many responses must be dropped after a flush.
// Latency: counters update on the clock edge; room/drop are combinational from registered state.
// Backpressure: room deasserts when MAX_OUTSTANDING requests are in flight; count saturates.
module fetch_track #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic req_fire,
  input  logic inst_valid,
  input  logic flush,
  output logic room,
  output logic drop_active
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;

  assign room        = (outstanding < MAX_C);
  assign drop_active = (discard_cnt != '0);

  // In-flight request count: request and response in the same cycle cancel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
    end else if (req_fire && !inst_valid && (outstanding < MAX_C)) begin
      outstanding <= outstanding + ONE_C;
    end else if (inst_valid && !req_fire && (outstanding != '0)) begin
      outstanding <= outstanding - ONE_C;
    end
  end

  // Responses still owed to the stale stream are counted off and dropped;
  // a response arriving with the flush itself is already accounted for.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else if (flush) begin
      discard_cnt <= (inst_valid && (outstanding != '0)) ? (outstanding - ONE_C) : outstanding;
    end else if (inst_valid && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - ONE_C;
    end
  end

endmodule

// File: rtl/ifid_ctrl.sv
// IF/ID load/hold/flush sequencing and fetch-redirect handshake (optional IFID_PERF_CNT_EN counters).
// Latency: ifid_load/ifid_flush combinational; redirect_valid/redirect_pc one cycle after the flush event.
// Backpressure: redirect held until redirect_ack; if_allow_req low while redirecting or fetch window full.
module ifid_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req_fire,
  input  logic        if_inst_valid,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic        wb_is_ertn,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era,
  input  logic        redirect_ack,
  output logic        ifid_load,
  output logic        ifid_flush,
  output logic        id_valid,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        if_allow_req
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cnt
`endif
);

  ifid_state_e state;
  logic        redir_hi_pri;   // pending redirect came from an exception or ertn
  logic        br_eff;
  logic        flush_evt;
  logic [31:0] flush_pc;
  logic        room;
  logic        drop_active;

  // A branch from the wrong-path stream must not override an exception/ertn redirect.
  assign br_eff     = br_taken && !((state == REDIRECT) && redir_hi_pri);
  assign flush_evt  = wb_ex || wb_is_ertn || br_eff;
  assign flush_pc   = flush_target(wb_ex, wb_is_ertn, ex_entry, era, br_target);

  assign ifid_flush = flush_evt;
  assign ifid_load  = if_inst_valid && (state == RUN) && !hazard_stall
                      && !drop_active && !flush_evt;
  // redirect_valid also gates fetch so nothing is issued before the reset PC is accepted.
  assign if_allow_req = room && (state != REDIRECT) && !redirect_valid;

  fetch_track #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_track (
    .clk         (clk),
    .resetn      (resetn),
    .req_fire    (if_req_fire),
    .inst_valid  (if_inst_valid),
    .flush       (flush_evt),
    .room        (room),
    .drop_active (drop_active)
  );

  // Sequencing FSM with registered redirect request; a new flush always wins over ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= RUN;
      redirect_valid <= 1'b1;
      redirect_pc    <= RESET_PC;
      redir_hi_pri   <= 1'b0;
    end else if (flush_evt) begin
      state          <= REDIRECT;
      redirect_valid <= 1'b1;
      redirect_pc    <= flush_pc;
      redir_hi_pri   <= wb_ex || wb_is_ertn;
    end else begin
      if (redirect_valid && redirect_ack) begin
        redirect_valid <= 1'b0;
      end
      case (state)
        RUN:      if (hazard_stall) state <= STALL;
        STALL:    if (!hazard_stall) state <= RUN;
        REDIRECT: if (redirect_ack) begin
                    state        <= RUN;
                    redir_hi_pri <= 1'b0;
                  end
        default:  state <= RUN;
      endcase
    end
  end

  // Liveness of the IF/ID content: flush kills, load fills, an unfilled advance drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_valid <= 1'b0;
    end else if (ifid_flush) begin
      id_valid <= 1'b0;
    end else if (ifid_load) begin
      id_valid <= 1'b1;
    end else if ((state == RUN) && !hazard_stall) begin
      id_valid <= 1'b0;
    end
  end

`ifdef IFID_PERF_CNT_EN
  // Free-running wrap-around event counters for stall cycles and flushes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (state == STALL) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_evt)      perf_flush_cnt    <= perf_flush_cnt + 32'd1;
    end
  end
`else
  // Counters compiled out; control behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ifid_ctrl.sv
// Directed self-checking bench for ifid_ctrl.
// Latency: inputs driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: redirect_ack driven explicitly per vector.
module tb_ifid_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req_fire, if_inst_valid, hazard_stall, br_taken;
  logic [31:0] br_target;
  logic        wb_ex, wb_is_ertn;
  logic [31:0] ex_entry, era;
  logic        redirect_ack;
  logic        ifid_load, ifid_flush, id_valid, redirect_valid, if_allow_req;
  logic [31:0] redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifid_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .if_req_fire    (if_req_fire),
    .if_inst_valid  (if_inst_valid),
    .hazard_stall   (hazard_stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .wb_ex          (wb_ex),
    .wb_is_ertn     (wb_is_ertn),
    .ex_entry       (ex_entry),
    .era            (era),
    .redirect_ack   (redirect_ack),
    .ifid_load      (ifid_load),
    .ifid_flush     (ifid_flush),
    .id_valid       (id_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_allow_req   (if_allow_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    if_req_fire   = 1'b0;
    if_inst_valid = 1'b0;
    hazard_stall  = 1'b0;
    br_taken      = 1'b0;
    wb_ex         = 1'b0;
    wb_is_ertn    = 1'b0;
    redirect_ack  = 1'b0;
  endtask

  // Start of a new cycle: wait for the falling edge and clear all strobes.
  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    resetn = 1'b0; idle();
    br_target = '0; ex_entry = '0; era = '0;

    // Reset values
    @(negedge clk); #1;
    check("rst_rv",    {31'd0, redirect_valid}, 32'd1);
    check("rst_pc",    redirect_pc, 32'h1c000000);
    check("rst_idv",   {31'd0, id_valid},     32'd0);
    check("rst_load",  {31'd0, ifid_load},    32'd0);
    check("rst_flush", {31'd0, ifid_flush},   32'd0);
    check("rst_allow", {31'd0, if_allow_req}, 32'd0);

    // Cycle 1: release reset, no ack yet
    next_cycle(); resetn = 1'b1; #1;
    check("c1_allow", {31'd0, if_allow_req}, 32'd0);
    // Cycle 2: ack the reset redirect
    next_cycle(); redirect_ack = 1'b1; #1;
    check("c2_pc",    redirect_pc, 32'h1c000000);
    check("c2_allow", {31'd0, if_allow_req}, 32'd0);
    // Cycle 3: fetch allowed, issue one request (outstanding 1)
    next_cycle(); if_req_fire = 1'b1; #1;
    check("c3_allow", {31'd0, if_allow_req},   32'd1);
    check("c3_rv",    {31'd0, redirect_valid}, 32'd0);
    // Cycle 4: response + request, loads IF/ID
    next_cycle(); if_inst_valid = 1'b1; if_req_fire = 1'b1; #1;
    check("c4_load", {31'd0, ifid_load}, 32'd1);

    // Cycles 5-7: hazard stall with responses arriving
    for (int i = 0; i < 3; i++) begin
      next_cycle(); hazard_stall = 1'b1; if_inst_valid = 1'b1; if_req_fire = 1'b1; #1;
      check("stall_load", {31'd0, ifid_load}, 32'd0);
      check("stall_idv",  {31'd0, id_valid},  32'd1);
    end
    // Cycle 8: stall drops, still in STALL this cycle
    next_cycle(); #1;
    check("c8_idv", {31'd0, id_valid}, 32'd1);
    // Cycle 9: second request (outstanding 2), ID drains
    next_cycle(); if_req_fire = 1'b1; #1;
    check("c9_allow", {31'd0, if_allow_req}, 32'd1);
    check("c9_idv",   {31'd0, id_valid},     32'd1);

    // Cycle 10: taken branch with 2 outstanding
    next_cycle(); br_taken = 1'b1; br_target = 32'h1c000040; #1;
    check("c10_allow", {31'd0, if_allow_req}, 32'd0);
    check("c10_idv",   {31'd0, id_valid},     32'd0);
    check("c10_flush", {31'd0, ifid_flush},   32'd1);
    check("c10_load",  {31'd0, ifid_load},    32'd0);
    // Cycle 11: first stale response, ack redirect
    next_cycle(); if_inst_valid = 1'b1; redirect_ack = 1'b1; #1;
    check("c11_rv",    {31'd0, redirect_valid}, 32'd1);
    check("c11_pc",    redirect_pc, 32'h1c000040);
    check("c11_flush", {31'd0, ifid_flush}, 32'd0);
    check("c11_load",  {31'd0, ifid_load},  32'd0);
    // Cycle 12: second stale response dropped while in RUN
    next_cycle(); if_inst_valid = 1'b1; #1;
    check("c12_rv",    {31'd0, redirect_valid}, 32'd0);
    check("c12_drop",  {31'd0, ifid_load},      32'd0);
    check("c12_allow", {31'd0, if_allow_req},   32'd1);
    // Cycles 13-14: fresh fetch loads normally
    next_cycle(); if_req_fire = 1'b1; #1;
    check("c13_allow", {31'd0, if_allow_req}, 32'd1);
    next_cycle(); if_inst_valid = 1'b1; #1;
    check("c14_load", {31'd0, ifid_load}, 32'd1);

    // Cycle 15: exception and branch together
    next_cycle(); wb_ex = 1'b1; br_taken = 1'b1; ex_entry = 32'h1c008000; br_target = 32'h1c000040; #1;
    check("c15_flush", {31'd0, ifid_flush}, 32'd1);
    check("c15_idv",   {31'd0, id_valid},   32'd1);
    // Cycle 16: branch during exception redirect is ignored
    next_cycle(); br_taken = 1'b1; br_target = 32'h1c000080; #1;
    check("c16_flush", {31'd0, ifid_flush},     32'd0);
    check("c16_rv",    {31'd0, redirect_valid}, 32'd1);
    check("c16_pc",    redirect_pc, 32'h1c008000);
    check("c16_idv",   {31'd0, id_valid},       32'd0);
    // Cycle 17: target unchanged, ack
    next_cycle(); redirect_ack = 1'b1; #1;
    check("c17_pc", redirect_pc, 32'h1c008000);

    // Cycle 18: branch redirect
    next_cycle(); br_taken = 1'b1; br_target = 32'h1c000040; #1;
    check("c18_rv",    {31'd0, redirect_valid}, 32'd0);
    check("c18_flush", {31'd0, ifid_flush},     32'd1);
    // Cycle 19: ertn while branch redirect pending
    next_cycle(); wb_is_ertn = 1'b1; era = 32'h1c000100; #1;
    check("c19_pc",    redirect_pc, 32'h1c000040);
    check("c19_flush", {31'd0, ifid_flush}, 32'd1);
    // Cycle 20: ack together with a new exception flush
    next_cycle(); redirect_ack = 1'b1; wb_ex = 1'b1; ex_entry = 32'h1c008000; #1;
    check("c20_pc", redirect_pc, 32'h1c000100);
    check("c20_rv", {31'd0, redirect_valid}, 32'd1);
    // Cycle 21: re-armed by the new flush
    next_cycle(); redirect_ack = 1'b1; #1;
    check("c21_rv", {31'd0, redirect_valid}, 32'd1);
    check("c21_pc", redirect_pc, 32'h1c008000);

    // Cycles 22-23: one request in flight, then a branch (discard 1)
    next_cycle(); if_req_fire = 1'b1; #1;
    check("c22_rv",    {31'd0, redirect_valid}, 32'd0);
    check("c22_allow", {31'd0, if_allow_req},   32'd1);
    next_cycle(); br_taken = 1'b1; br_target = 32'h1c000200; #1;
    check("c23_flush", {31'd0, ifid_flush}, 32'd1);
    // Cycle 24: reset asserted mid-redirect
    next_cycle(); #1;
    check("c24_disc", 32'(dut.u_track.discard_cnt), 32'd1);
    check("c24_outs", 32'(dut.u_track.outstanding), 32'd1);
    check("c24_rv",   {31'd0, redirect_valid}, 32'd1);
    resetn = 1'b0; #1;
    check("arst_disc",  32'(dut.u_track.discard_cnt), 32'd0);
    check("arst_outs",  32'(dut.u_track.outstanding), 32'd0);
    check("arst_idv",   {31'd0, id_valid},       32'd0);
    check("arst_rv",    {31'd0, redirect_valid}, 32'd1);
    check("arst_pc",    redirect_pc, 32'h1c000000);
    check("arst_allow", {31'd0, if_allow_req},   32'd0);

    // Restart and exercise outstanding saturation
    next_cycle(); resetn = 1'b1;
    next_cycle(); redirect_ack = 1'b1;
    next_cycle(); if_req_fire = 1'b1; #1;
    check("r1_allow", {31'd0, if_allow_req}, 32'd1);
    next_cycle(); if_req_fire = 1'b1;
    next_cycle(); if_req_fire = 1'b1; #1;
    check("sat_allow", {31'd0, if_allow_req}, 32'd0);
    next_cycle(); if_inst_valid = 1'b1; #1;
    check("sat_load",  {31'd0, ifid_load},    32'd1);
    check("sat_allow2", {31'd0, if_allow_req}, 32'd0);
    next_cycle(); #1;
    check("sat_allow3", {31'd0, if_allow_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_ctrl.md
# ifid_ctrl

Sequencing controller for the IF/ID pipeline register in the exp12 LoongArch core. It decides each cycle whether the IF/ID register loads, holds or flushes, and drives the fetch-redirect handshake toward the PC generator. It also discards a fetch response that is still in flight when a flush hits. It sits between the IF stage, the hazard unit, the EX branch resolver and the WB exception/ertn path.

## Interface
- `RESET_PC`, default 32'h1c000000: fetch PC requested after reset.
- `MAX_OUTSTANDING`, default 2: maximum number of in-flight fetch requests tracked.
- `clk` in 1: clock. All state is updated on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `if_req_fire` in 1: a fetch request was accepted by the instruction SRAM this cycle.
- `if_inst_valid` in 1: a fetch response (instruction) is available this cycle.
- `hazard_stall` in 1: load-use or CSR hazard from ID; the IF/ID register must hold.
- `br_taken` in 1: EX resolved a taken branch or jump.
- `br_target` in 32: branch target PC.
- `wb_ex` in 1: exception committed in WB.
- `wb_is_ertn` in 1: ertn committed in WB.
- `ex_entry` in 32: exception entry PC (CSR EENTRY).
- `era` in 32: ertn return PC (CSR ERA).
- `redirect_ack` in 1: the PC generator accepted the redirect.
- `ifid_load` out 1: IF/ID register captures `if_pc`/`if_inst`.
- `ifid_flush` out 1: IF/ID register resets to pc 32'h1bfffffc, inst 0.
- `id_valid` out 1: the IF/ID register content is a live instruction.
- `redirect_valid` out 1: redirect request to the PC generator.
- `redirect_pc` out 32: redirect target.
- `if_allow_req` out 1: IF may issue a new fetch request.

## Operation
- States: RUN, STALL, REDIRECT.
  - RUN → STALL on `hazard_stall`.
  - STALL → RUN when `hazard_stall` drops.
  - Any state → REDIRECT on a flush event.
  - REDIRECT → RUN on `redirect_ack`.
- Flush event priority: `wb_ex` > `wb_is_ertn` > `br_taken`. Target is `ex_entry`, `era` or `br_target` respectively.
- A flush event always wins over `hazard_stall`. A higher-priority event arriving during REDIRECT replaces `redirect_pc` and keeps `redirect_valid` high. A `br_taken` during a pending exception/ertn redirect is ignored.
- `ifid_flush` = any flush event (combinational, same cycle).
- `ifid_load` = `if_inst_valid` && state==RUN && !`hazard_stall` && `discard_cnt`==0 && no flush event.
- `outstanding` counter:
  - +1 on `if_req_fire`, −1 on `if_inst_valid`; simultaneous events leave it unchanged.
  - Saturates at `MAX_OUTSTANDING`.
  - `if_allow_req` = (`outstanding` < `MAX_OUTSTANDING`) && state != REDIRECT.
- `discard_cnt`:
  - On a flush event it loads `outstanding` (or `outstanding`−1 if `if_inst_valid` is high that same cycle).
  - It decrements on each `if_inst_valid` while nonzero; those responses are dropped.
- `id_valid`:
  - Set on `ifid_load`.
  - Cleared on `ifid_flush`, or when ID advances with no new load (state RUN, no stall, no `ifid_load`).
  - Held in STALL.

## Timing
- Reset values:
  - state RUN
  - `redirect_valid` 1, `redirect_pc` = `RESET_PC`
  - `id_valid` 0
  - `outstanding` 0, `discard_cnt` 0
  - `ifid_load` 0, `ifid_flush` 0
  - `if_allow_req` 0 until `redirect_ack`
- `ifid_load` and `ifid_flush` are combinational (0-cycle).
- `redirect_valid`/`redirect_pc` are registered: asserted the cycle after the flush event and held until the cycle `redirect_ack` is sampled high.
- Redirect and ack in the same cycle as a new flush: the new flush re-arms `redirect_valid` the next cycle.
- `resetn` low mid-redirect: all in-flight state is cleared immediately and the core restarts at `RESET_PC`.

## Configuration
- `IFID_PERF_CNT_EN` defined:
  - Adds 32-bit wrap-around counters `perf_stall_cycles` (cycles in STALL) and `perf_flush_cnt` (flush events), reset to 0.
  - Adds both as output ports.
- Undefined: no counters and no ports. Functional behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - state enum (RUN=0, STALL=1, REDIRECT=2)
  - constants `IFID_FLUSH_PC` = 32'h1bfffffc and `RESET_PC_DEFAULT`
- One sub-module `fetch_track`: the `outstanding`/`discard_cnt` counters and drop logic.

## Test plan
- Reset release with `redirect_ack` in cycle 2 → `redirect_pc` = 0x1c000000; `if_allow_req` rises in cycle 3.
- `hazard_stall` high 3 cycles with `if_inst_valid` → `ifid_load` 0 for 3 cycles; `id_valid` held at 1.
- `br_taken`, target 0x1c000040, with 2 outstanding fetches → `ifid_flush` same cycle; next 2 responses dropped; `redirect_pc` 0x1c000040.
- `wb_ex` and `br_taken` in the same cycle, `ex_entry` 0x1c008000 → `redirect_pc` 0x1c008000.
- `wb_is_ertn` (`era` 0x1c000100) while REDIRECT is pending for a branch → `redirect_pc` becomes 0x1c000100; `redirect_valid` stays high.
- `resetn` low during REDIRECT with `discard_cnt`=1 → all counters 0, `id_valid` 0 immediately.
